// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: round-robin grant of one write and two read clients onto a byte array.
// Optional MEM_RESP_ERR_EN: out-of-range accesses are suppressed and flagged on sticky mem_err.
module mem_resp_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned MEM_DATA_BUS = 128,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned SIZE_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdp_req,
  input  logic [ADDR_WIDTH-1:0]   rdp_start_addr,
  input  logic [SIZE_WIDTH-1:0]   rdp_size_bytes,
  output logic                    rdp_gnt,
  output logic [MEM_DATA_BUS-1:0] rdp_data,
  input  logic                    rdw_req,
  input  logic [ADDR_WIDTH-1:0]   rdw_start_addr,
  input  logic [SIZE_WIDTH-1:0]   rdw_size_bytes,
  output logic                    rdw_gnt,
  output logic [MEM_DATA_BUS-1:0] rdw_data,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_start_addr,
  input  logic [SIZE_WIDTH-1:0]   wr_size_bytes,
  input  logic [MEM_DATA_BUS-1:0] wr_data,
  output logic                    wr_gnt,
  output logic                    mem_err
);

  localparam int unsigned NumBytes = MEM_DATA_BUS / 8;
  localparam int unsigned IdxW     = $clog2(MEM_BYTES);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;

  localparam logic [1:0] ClWr  = 2'd0;
  localparam logic [1:0] ClPic = 2'd1;
  localparam logic [1:0] ClWgt = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [1:0]              last_q;
  logic [1:0]              win_q, win_d;
  logic                    win_vld;
  logic [2:0]              req, elig;
  logic [ADDR_WIDTH-1:0]   addr_q, sel_addr;
  logic [SIZE_WIDTH-1:0]   size_q, sel_size, clamp_size;
  logic [MEM_DATA_BUS-1:0] wdata_q;
  logic [2:0]              gnt_q;
  logic [MEM_DATA_BUS-1:0] rdp_data_q, rdw_data_q, rd_word;
  logic                    acc_err;
  logic                    do_access;

  logic [7:0] mem [MEM_BYTES];

  assign req = {rdw_req, rdp_req, wr_req};

  // A client stays blind for two cycles after its grant cycle because its req drops late.
  for (genvar c = 0; c < 3; c++) begin : g_hold
    logic [1:0] hold_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= 2'd0;
      end else if (state_q == StAccess && win_q == 2'(c)) begin
        hold_q <= 2'd3;
      end else if (hold_q != 2'd0) begin
        hold_q <= hold_q - 2'd1;
      end
    end
    assign elig[c] = req[c] && (hold_q == 2'd0);
  end

  // Search downwards so the client right after last_q is assigned last and wins.
  always_comb begin
    logic [1:0] cand;
    win_vld = 1'b0;
    win_d   = last_q;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_d   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = wr_start_addr;
    sel_size = wr_size_bytes;
    case (win_d)
      ClPic: begin
        sel_addr = rdp_start_addr;
        sel_size = rdp_size_bytes;
      end
      ClWgt: begin
        sel_addr = rdw_start_addr;
        sel_size = rdw_size_bytes;
      end
      default: ;
    endcase
    clamp_size = (sel_size > SIZE_WIDTH'(NumBytes)) ? SIZE_WIDTH'(NumBytes) : sel_size;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (win_vld) state_d = StAccess;
      StAccess: state_d = StGap;
      default:  state_d = StIdle;
    endcase
  end

  assign do_access = (state_q == StAccess);

`ifdef MEM_RESP_ERR_EN
  localparam int unsigned AddrW1 = ADDR_WIDTH + 1;
  logic [AddrW1-1:0] end_addr;
  logic              err_q;

  assign end_addr = {1'b0, addr_q} + AddrW1'(size_q);
  assign acc_err  = (addr_q >= ADDR_WIDTH'(MEM_BYTES)) || (end_addr > AddrW1'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (do_access && acc_err) begin
      err_q <= 1'b1;
    end
  end
  assign mem_err = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[ADDR_WIDTH-1:IdxW];
  assign acc_err        = 1'b0;
  assign mem_err        = 1'b0;
`endif

  function automatic logic [IdxW-1:0] byte_idx(input int unsigned i);
    return addr_q[IdxW-1:0] + IdxW'(i);
  endfunction

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (!acc_err && SIZE_WIDTH'(i) < size_q) rd_word[8*i +: 8] = mem[byte_idx(i)];
    end
  end

  // Storage is deliberately unreset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_access && win_q == ClWr && !acc_err) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (SIZE_WIDTH'(i) < size_q) mem[byte_idx(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= ClWgt;
      win_q      <= ClWr;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      rdp_data_q <= '0;
      rdw_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            win_q   <= win_d;
            last_q  <= win_d;
            addr_q  <= sel_addr;
            size_q  <= clamp_size;
            wdata_q <= wr_data;
          end
        end
        StAccess: begin
          gnt_q <= 3'b001 << win_q;
          if (win_q == ClPic) rdp_data_q <= rd_word;
          if (win_q == ClWgt) rdw_data_q <= rd_word;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign wr_gnt   = gnt_q[0];
  assign rdp_gnt  = gnt_q[1];
  assign rdw_gnt  = gnt_q[2];
  assign rdp_data = rdp_data_q;
  assign rdw_data = rdw_data_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: directed cases plus randomized clients against a
// cycle-timed reference model of grants, storage bytes and held read data.
module tb_mem_resp_ctrl;

  localparam int MB = 4096;
  localparam logic [127:0] Pat = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] All = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rdp_req = 1'b0, rdw_req = 1'b0, wr_req = 1'b0;
  logic [18:0]  rdp_start_addr = '0, rdw_start_addr = '0, wr_start_addr = '0;
  logic [4:0]   rdp_size_bytes = '0, rdw_size_bytes = '0, wr_size_bytes = '0;
  logic [127:0] wr_data = '0;
  logic         rdp_gnt, rdw_gnt, wr_gnt, mem_err;
  logic [127:0] rdp_data, rdw_data;

  mem_resp_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdp_req        (rdp_req),
    .rdp_start_addr (rdp_start_addr),
    .rdp_size_bytes (rdp_size_bytes),
    .rdp_gnt        (rdp_gnt),
    .rdp_data       (rdp_data),
    .rdw_req        (rdw_req),
    .rdw_start_addr (rdw_start_addr),
    .rdw_size_bytes (rdw_size_bytes),
    .rdw_gnt        (rdw_gnt),
    .rdw_data       (rdw_data),
    .wr_req         (wr_req),
    .wr_start_addr  (wr_start_addr),
    .wr_size_bytes  (wr_size_bytes),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input logic [127:0] msk);
    checks++;
    if ((act & msk) !== (exp & msk)) begin
      failures++;
      $display("FAIL %s: got %h required %h (mask %h) at %0t", name, act, exp, msk, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A decision at edge D shows gnt after edge D+1 and drops at D+2; the next decision is at
  // D+3 or later; the winner ignores its own req at D+3 and D+4.
  int cyc = 0, next_ok = 0, last_win = 2, pend_dec = -100, pend_c = 0;
  int last_dec[3] = '{-100, -100, -100};
  int           ps = 0;
  logic [18:0]  pa = '0;
  logic [127:0] pd = '0;
  logic [7:0]   mmem [MB];
  bit           known [MB];
  logic [127:0] e_rdp = '0, m_rdp = '1, e_rdw = '0, m_rdw = '1;
  logic [2:0]   e_gnt = '0;
  logic         e_err = 1'b0;

  function automatic bit in_range(input int a, input int s);
`ifdef MEM_RESP_ERR_EN
    return (a < MB) && (a + s <= MB);
`else
    return (a >= 0) && (s >= 0);
`endif
  endfunction

  task automatic model_access();
    logic [127:0] e, m;
    bit ok;
    int idx;
    ok = in_range(int'(pa), ps);
    e = '0;
    m = '1;
    if (!ok) e_err = 1'b1;
    if (pend_c == 0) begin
      if (ok) begin
        for (int i = 0; i < ps; i++) begin
          idx = (int'(pa) + i) % MB;
          mmem[idx] = pd[8*i +: 8];
          known[idx] = 1'b1;
        end
      end
    end else begin
      if (ok) begin
        for (int i = 0; i < ps; i++) begin
          idx = (int'(pa) + i) % MB;
          e[8*i +: 8] = mmem[idx];
          m[8*i +: 8] = known[idx] ? 8'hFF : 8'h00;
        end
      end
      if (pend_c == 1) begin e_rdp = e; m_rdp = m; end
      else begin e_rdw = e; m_rdw = m; end
    end
    e_gnt = 3'b001 << pend_c;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt = '0; e_rdp = '0; m_rdp = '1; e_rdw = '0; m_rdw = '1; e_err = 1'b0;
      last_win = 2; pend_dec = -100; next_ok = 0;
      for (int c = 0; c < 3; c++) last_dec[c] = -100;
    end else begin
      logic [2:0] r;
      int c;
      cyc++;
      r = {rdw_req, rdp_req, wr_req};
      if (cyc == pend_dec + 2) e_gnt = '0;
      if (cyc == pend_dec + 1) model_access();
      if (cyc >= next_ok) begin
        for (int k = 1; k <= 3; k++) begin
          c = (last_win + k) % 3;
          if (r[c] && cyc != last_dec[c] + 3 && cyc != last_dec[c] + 4) begin
            case (c)
              0: begin pa = wr_start_addr;  ps = int'(wr_size_bytes); end
              1: begin pa = rdp_start_addr; ps = int'(rdp_size_bytes); end
              default: begin pa = rdw_start_addr; ps = int'(rdw_size_bytes); end
            endcase
            if (ps > 16) ps = 16;
            pd = wr_data;
            pend_c = c; pend_dec = cyc; next_ok = cyc + 3; last_dec[c] = cyc; last_win = c;
            break;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_gnt", {127'd0, wr_gnt}, {127'd0, e_gnt[0]}, All);
    chk("rdp_gnt", {127'd0, rdp_gnt}, {127'd0, e_gnt[1]}, All);
    chk("rdw_gnt", {127'd0, rdw_gnt}, {127'd0, e_gnt[2]}, All);
    chk("rdp_data", rdp_data, e_rdp, m_rdp);
    chk("rdw_data", rdw_data, e_rdw, m_rdw);
    chk("mem_err", {127'd0, mem_err}, {127'd0, e_err}, All);
  end

  // ---------------- stimulus ----------------
  function automatic logic gnt_of(input int c);
    case (c)
      0: return wr_gnt;
      1: return rdp_gnt;
      default: return rdw_gnt;
    endcase
  endfunction

  task automatic set_req(input int c, input logic v);
    case (c)
      0: wr_req = v;
      1: rdp_req = v;
      default: rdw_req = v;
    endcase
  endtask

  task automatic txn(input int c, input logic [18:0] a, input logic [4:0] s,
                     input logic [127:0] d, input int hold, input int gap, output int lat);
    bit got = 1'b0;
    @(negedge clk);
    case (c)
      0: begin wr_start_addr = a; wr_size_bytes = s; wr_data = d; end
      1: begin rdp_start_addr = a; rdp_size_bytes = s; end
      default: begin rdw_start_addr = a; rdw_size_bytes = s; end
    endcase
    set_req(c, 1'b1);
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = gnt_of(c);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gnt_timeout client %0d: got no grant in %0d cycles, required one", c, lat);
    end
    repeat (hold) @(negedge clk);
    set_req(c, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [18:0] rnd_addr();
    int r = $urandom_range(0, 9);
    if (r < 7) return 19'($urandom_range(0, 255));
    if (r < 9) return 19'($urandom_range(0, MB - 1));
    return 19'($urandom_range(MB - 16, MB + 300));
  endfunction

  task automatic rand_client(input int c);
    int lat;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn(c, rnd_addr(), 5'($urandom_range(0, 31)),
          {$urandom(), $urandom(), $urandom(), $urandom()}, $urandom_range(0, 3), 0, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, l2;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnts", {125'd0, rdw_gnt, rdp_gnt, wr_gnt}, '0, All);
    chk("rst_rdp_data", rdp_data, '0, All);
    chk("rst_rdw_data", rdw_data, '0, All);
    chk("rst_mem_err", {127'd0, mem_err}, '0, All);
    @(negedge clk);
    rst_n = 1'b1;

    // All three requests from reset: order wr, pic, wgt, three cycles apart.
    fork
      txn(0, 19'h10, 5'd16, Pat, 2, 0, l0);
      txn(1, 19'h10, 5'd16, '0, 2, 0, l1);
      txn(2, 19'h40, 5'd8, '0, 2, 0, l2);
    join
    chk("lat_wr", 128'(l0), 128'd2, All);
    chk("lat_rdp", 128'(l1), 128'd5, All);
    chk("lat_rdw", 128'(l2), 128'd8, All);
    chk("wr_then_rd", rdp_data, Pat, All);
    repeat (3) @(negedge clk);

    txn(1, 19'h10, 5'd16, '0, 1, 3, l1);
    chk("lat_single", 128'(l1), 128'd2, All);
    chk("rd_16", rdp_data, Pat, All);
    txn(1, 19'h12, 5'd4, '0, 1, 3, l1);
    chk("rd_12_4", rdp_data, 128'h05040302, All);
    txn(2, 19'h100, 5'd4, '0, 1, 3, l2);
    chk("rdp_hold", rdp_data, 128'h05040302, All);

    txn(0, 19'h10, 5'd0, '1, 1, 3, l0);
    txn(1, 19'h10, 5'd20, '0, 1, 3, l1);
    chk("size0_size20", rdp_data, Pat, All);

    txn(0, 19'hFFE, 5'd4, 128'hDDCCBBAA, 1, 3, l0);
    txn(2, 19'hFFE, 5'd4, '0, 1, 3, l2);
`ifdef MEM_RESP_ERR_EN
    chk("err_rd_zero", rdw_data, '0, All);
    chk("err_set", {127'd0, mem_err}, 128'd1, All);
    txn(1, 19'h10, 5'd4, '0, 1, 3, l1);
    chk("err_sticky", {127'd0, mem_err}, 128'd1, All);
`else
    chk("wrap_rd", rdw_data, 128'hDDCCBBAA, All);
    txn(2, 19'h000, 5'd2, '0, 1, 3, l2);
    chk("wrap_low", rdw_data, 128'hDDCC, All);
    chk("no_err", {127'd0, mem_err}, 128'd0, All);
`endif

    // Reset while a pic read is in its access cycle.
    @(negedge clk);
    rdp_start_addr = 19'h10;
    rdp_size_bytes = 5'd16;
    rdp_req = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    rdp_req = 1'b0;
    #1;
    chk("rst_mid_gnt", {125'd0, rdw_gnt, rdp_gnt, wr_gnt}, '0, All);
    chk("rst_mid_data", rdp_data, '0, All);
    @(negedge clk);
    #1 chk("rst_mid_gnt2", {127'd0, rdp_gnt}, '0, All);
    @(negedge clk);
    #2 rst_n = 1'b1;
    txn(1, 19'h10, 5'd16, '0, 1, 3, l1);
    chk("post_rst_lat", 128'(l1), 128'd2, All);
    chk("post_rst_data", rdp_data, Pat, All);

    fork
      rand_client(0);
      rand_client(1);
      rand_client(2);
    join
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
